keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_keypad_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning matrix keypad with whole-scan debounce and press events.
// Optional KEYPAD_RELEASE_EN adds the key_rel release pulse output.
module keypad_scanner #(
    parameter int N_COL  = 4,
    parameter int N_ROW  = 4,
    parameter int L_BIT  = 4,
    parameter int SETTLE = 2,
    localparam int CODE_W = $clog2(N_ROW * N_COL)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ce,
    input  logic [N_ROW-1:0]  row_n,
    output logic [N_COL-1:0]  col_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_down
`ifdef KEYPAD_RELEASE_EN
    ,
    output logic              key_rel
`endif
);

    localparam int NK     = N_ROW * N_COL;
    localparam int CIDX_W = $clog2(N_COL);
    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int RES_W  = CODE_W + 1;

    logic [N_ROW-1:0]       row_s1_q, row_s2_q;
    logic [CIDX_W-1:0]      col_q, col_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_COL-1:0]       col_n_q, col_n_d;
    logic [NK-1:0]          snap_q, snap_d;
    logic [L_BIT*RES_W-1:0] hist_q, hist_d;
    logic [RES_W-1:0]       stable_q, stable_d;
    logic [CODE_W-1:0]      key_code_q, key_code_d;
    logic                   key_valid_q, key_valid_d;
    logic                   key_down_q, key_down_d;
    logic                   scan_done;
    logic                   all_same;
    int                     ones;
    logic [CODE_W-1:0]      res_code;
    logic [RES_W-1:0]       res;
`ifdef KEYPAD_RELEASE_EN
    logic                   key_rel_q, key_rel_d;
`endif

    always_comb begin
        cnt_d       = cnt_q;
        col_d       = col_q;
        col_n_d     = col_n_q;
        snap_d      = snap_q;
        hist_d      = hist_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        key_valid_d = 1'b0;
        scan_done   = 1'b0;
        all_same    = 1'b1;
        ones        = 0;
        res_code    = '0;
        res         = '0;
`ifdef KEYPAD_RELEASE_EN
        key_rel_d   = 1'b0;
`endif
        if (ce) begin
            if (cnt_q != CNT_W'(SETTLE)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                for (int r = 0; r < N_ROW; r++) begin
                    snap_d[r*N_COL + int'(col_q)] = ~row_s2_q[r];
                end
                if (col_q == CIDX_W'(N_COL - 1)) begin
                    col_d     = '0;
                    scan_done = 1'b1;
                end else begin
                    col_d = col_q + CIDX_W'(1);
                end
                col_n_d = ~(N_COL'(1) << col_d);
            end
        end

        // Scan result uses the snapshot including the column sampled this tick.
        for (int i = 0; i < NK; i++) begin
            if (snap_d[i]) begin
                ones     = ones + 1;
                res_code = CODE_W'(i);
            end
        end
        res = (ones == 1) ? {1'b1, res_code} : '0;

        if (scan_done) begin
            hist_d = {hist_q[(L_BIT-1)*RES_W-1:0], res};
            for (int i = 1; i < L_BIT; i++) begin
                if (hist_d[i*RES_W +: RES_W] != res) all_same = 1'b0;
            end
            if (all_same && (res != stable_q)) begin
                stable_d = res;
`ifdef KEYPAD_RELEASE_EN
                key_rel_d = stable_q[CODE_W];
`endif
                if (res[CODE_W]) begin
                    key_code_d  = res[CODE_W-1:0];
                    key_down_d  = 1'b1;
                    key_valid_d = 1'b1;
                end else begin
                    key_down_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            row_s1_q    <= '1;
            row_s2_q    <= '1;
            col_q       <= '0;
            cnt_q       <= '0;
            col_n_q     <= ~(N_COL'(1));
            snap_q      <= '0;
            hist_q      <= '0;
            stable_q    <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
            key_rel_q   <= 1'b0;
`endif
        end else begin
            row_s1_q    <= row_n;
            row_s2_q    <= row_s1_q;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            col_n_q     <= col_n_d;
            snap_q      <= snap_d;
            hist_q      <= hist_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
`ifdef KEYPAD_RELEASE_EN
            key_rel_q   <= key_rel_d;
`endif
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
`ifdef KEYPAD_RELEASE_EN
    assign key_rel   = key_rel_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed checks of keypad_scanner against a simulated 4x4 key matrix.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        ce  = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys = '0;
`ifdef KEYPAD_RELEASE_EN
    logic        key_rel;
    int          rel_cnt = 0;
    int          rel_base;
`endif

    int   n_chk = 0;
    int   n_pass = 0;
    int   pulse_cnt = 0;
    int   dbl_cnt = 0;
    int   base;
    logic prev_v = 1'b0;

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    keypad_scanner dut (
        .clk       (clk),
        .clr       (clr),
        .ce        (ce),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
`ifdef KEYPAD_RELEASE_EN
        ,
        .key_rel   (key_rel)
`endif
    );

    always @(posedge clk) begin
        if (key_valid) begin
            pulse_cnt++;
            if (prev_v) dbl_cnt++;
        end
        prev_v = key_valid;
`ifdef KEYPAD_RELEASE_EN
        if (key_rel) rel_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic ce_hit();
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
    endtask

    task automatic ce_gap();
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            ce_hit();
            ce_gap();
        end
    endtask

    task automatic do_reset(input logic [15:0] k);
        keys = k;
        @(negedge clk) begin clr = 1'b1; ce = 1'b0; end
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        base = pulse_cnt;
    endtask

    initial begin
        // Idle scanning, no key pressed.
        do_reset('0);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_down", key_down, 0);
        run(3);  check("col_n_c1", col_n, 4'b1101);
        run(3);  check("col_n_c2", col_n, 4'b1011);
        run(3);  check("col_n_c3", col_n, 4'b0111);
        run(3);  check("col_n_wrap", col_n, 4'b1110);
        run(188);
        check("idle_pulses", pulse_cnt - base, 0);
        check("idle_down", key_down, 0);

        // Key 6 held for 3 scans only, then for 4 scans.
        do_reset(16'h1 << 6);
        run(36);
        keys = '0;
        run(72);
        check("short_pulses", pulse_cnt - base, 0);
        check("short_down", key_down, 0);
        do_reset(16'h1 << 6);
        run(48);
        keys = '0;
        run(72);
        check("four_pulses", pulse_cnt - base, 1);
        check("four_rel_down", key_down, 0);
        check("four_code_hold", key_code, 6);

        // Key 15 bouncing on alternate scans, then held.
        do_reset('0);
        for (int s = 1; s <= 5; s++) begin
            keys = (s % 2 == 1) ? (16'h1 << 15) : 16'h0;
            run(12);
        end
        keys = 16'h1 << 15;
        run(35);
        check("bounce_early", pulse_cnt - base, 0);
        ce_hit();
        check("bounce_valid", key_valid, 1);
        check("bounce_code", key_code, 15);
        ce_gap();
        run(24);
        check("bounce_pulses", pulse_cnt - base, 1);

        // Keys 0 and 5 together, then 0 alone, then 5 alone.
        do_reset((16'h1 << 0) | (16'h1 << 5));
        run(72);
        check("multi_pulses", pulse_cnt - base, 0);
        check("multi_down", key_down, 0);
        keys = 16'h1 << 0;
        run(47);
        ce_hit();
        check("k0_valid", key_valid, 1);
        check("k0_code", key_code, 0);
        check("k0_down", key_down, 1);
        ce_gap();
        keys = 16'h1 << 5;
        run(47);
        check("k0k5_down_held", key_down, 1);
        ce_hit();
        check("k5_valid", key_valid, 1);
        check("k5_code", key_code, 5);
        ce_gap();
        check("k0k5_pulses", pulse_cnt - base, 2);

        // Key 9 from reset, then clr mid-scan, then reacquire and release.
        do_reset(16'h1 << 9);
        run(47);
        check("k9_early", pulse_cnt - base, 0);
        check("k9_early_down", key_down, 0);
        ce_hit();
        check("k9_valid", key_valid, 1);
        check("k9_code", key_code, 9);
        check("k9_down", key_down, 1);
        ce_gap();
        check("k9_single", key_valid, 0);
        check("k9_pulses", pulse_cnt - base, 1);
        run(5);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check("clr_col_n", col_n, 4'b1110);
        check("clr_down", key_down, 0);
        check("clr_code", key_code, 0);
        check("clr_valid", key_valid, 0);
        base = pulse_cnt;
        run(47);
        check("reacq_early", pulse_cnt - base, 0);
        ce_hit();
        check("reacq_valid", key_valid, 1);
        check("reacq_code", key_code, 9);
        ce_gap();
        keys = '0;
`ifdef KEYPAD_RELEASE_EN
        rel_base = rel_cnt;
`endif
        run(47);
        check("rel_down_held", key_down, 1);
        ce_hit();
        check("rel_down", key_down, 0);
        check("rel_code", key_code, 9);
        check("rel_no_valid", key_valid, 0);
`ifdef KEYPAD_RELEASE_EN
        check("rel_pulse", key_rel, 1);
`endif
        ce_gap();
`ifdef KEYPAD_RELEASE_EN
        check("rel_count", rel_cnt - rel_base, 1);
`endif
        check("rel_pulses", pulse_cnt - base, 1);
        check("no_back_to_back", dbl_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
